sdio_slotmux: RTL and testbench

SDIO_SLOTMUX -- requirements
Module: sdio_slotmux

---
 rtl/sdio_slotmux_pkg.sv | 17 +
 rtl/sdio_slotmux_if.sv | 21 ++
 rtl/sdio_slotmux_cdebounce.sv | 43 ++++
 rtl/sdio_slotmux.sv | 149 ++++++++++++++
 tb/tb_sdio_slotmux.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdio_slotmux_pkg.sv
// Shared state encoding and sizing helper for the SDIO slot multiplexer.
package sdio_slotmux_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_GATE   = 2'd2,
    ST_LOAD   = 2'd3
  } slotmux_state_t;

  // Width of slot-select fields. One code beyond the last slot is kept so an
  // out-of-range request can be expressed and rejected.
  function automatic int sel_width(input int nslots);
    return $clog2(nslots + 1);
  endfunction

endpackage

// File: rtl/sdio_slotmux_if.sv
// Slot-select handshake and switch status between a controller and sdio_slotmux.
interface sdio_slotmux_if #(
  parameter int SW = 2
);
  logic          i_sel_valid;
  logic          o_sel_ready;
  logic [SW-1:0] i_sel_slot;
  logic [SW-1:0] o_active_slot;
  logic          o_switching;
  logic          o_sel_err;

  modport master (
    output i_sel_valid, i_sel_slot,
    input  o_sel_ready, o_active_slot, o_switching, o_sel_err
  );

  modport slave (
    input  i_sel_valid, i_sel_slot,
    output o_sel_ready, o_active_slot, o_switching, o_sel_err
  );
endinterface

// File: rtl/sdio_slotmux_cdebounce.sv
// Card-detect conditioner: two-flop synchroniser followed by a stable-count debouncer.
module sdio_cdebounce #(
  parameter int LGDEBOUNCE = 16
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_card_detect,
  output logic o_present,
  output logic o_chg
);
  logic                  sync1_q, sync2_q;
  logic                  present_q, chg_q;
  logic [LGDEBOUNCE-1:0] cnt_q;

  // Counter only advances while the input disagrees with the reported state;
  // it clears on update, so it can never wrap.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      present_q <= 1'b0;
      chg_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q <= i_card_detect;
      sync2_q <= sync1_q;
      chg_q   <= 1'b0;
      if (sync2_q == present_q) begin
        cnt_q <= '0;
      end else if (cnt_q == '1) begin
        present_q <= sync2_q;
        chg_q     <= 1'b1;
        cnt_q     <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign o_present = present_q;
  assign o_chg     = chg_q;

endmodule

// File: rtl/sdio_slotmux.sv
// Shares one SDIO controller between NSLOTS card slots with a drained,
// clock-gated switch and per-slot card-detect debouncing.
//
// state  | meaning
// ACTIVE | pads connected to o_active_slot, accepting switch requests
// DRAIN  | waiting for controller and card busy to clear, pads still connected
// GATE   | all slots idle for SETTLE cycles
// LOAD   | target slot connected, o_active_slot updated on exit
module sdio_slotmux
  import sdio_slotmux_pkg::*;
#(
  parameter int NSLOTS     = 2,
  parameter int NUMIO      = 4,
  parameter int LGDEBOUNCE = 16,
  parameter int SETTLE     = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  sdio_slotmux_if.slave             sel_if,
  input  logic                      i_bus_busy,
  input  logic                      i_card_busy,
  input  logic                      i_core_ck,
  input  logic                      i_core_cmd_oe,
  input  logic                      i_core_cmd,
  input  logic [NUMIO-1:0]          i_core_dat_oe,
  input  logic [NUMIO-1:0]          i_core_dat,
  output logic                      o_core_cmd,
  output logic [NUMIO-1:0]          o_core_dat,
  output logic [NSLOTS-1:0]         o_slot_ck,
  output logic [NSLOTS-1:0]         o_slot_cmd_oe,
  output logic [NSLOTS-1:0]         o_slot_cmd,
  output logic [NSLOTS*NUMIO-1:0]   o_slot_dat_oe,
  output logic [NSLOTS*NUMIO-1:0]   o_slot_dat,
  input  logic [NSLOTS-1:0]         i_slot_cmd,
  input  logic [NSLOTS*NUMIO-1:0]   i_slot_dat,
  input  logic [NSLOTS-1:0]         i_card_detect,
  output logic [NSLOTS-1:0]         o_card_present,
  output logic                      o_present_chg
);
  localparam int            SW          = sel_width(NSLOTS);
  localparam logic [SW-1:0] SLOT_LIMIT  = SW'(NSLOTS);
  localparam logic [7:0]    SETTLE_LOAD = 8'(SETTLE - 1);

  slotmux_state_t state_q;
  logic [SW-1:0]  active_q, target_q, pad_sel_q;
  logic [7:0]     cnt_q;
  logic           ready_q, switching_q, err_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_ACTIVE;
      active_q    <= '0;
      target_q    <= '0;
      pad_sel_q   <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      switching_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_ACTIVE: begin
          if (sel_if.i_sel_valid && ready_q) begin
            if (sel_if.i_sel_slot >= SLOT_LIMIT) begin
              err_q <= 1'b1;
            end else if (sel_if.i_sel_slot != active_q) begin
              target_q    <= sel_if.i_sel_slot;
              state_q     <= ST_DRAIN;
              ready_q     <= 1'b0;
              switching_q <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (!i_bus_busy && !i_card_busy) begin
            state_q <= ST_GATE;
            cnt_q   <= SETTLE_LOAD;
          end
        end
        ST_GATE: begin
          // Pad mux moves to the target as gating ends, so LOAD never
          // re-clocks the slot being left.
          if (cnt_q == 8'd0) begin
            state_q   <= ST_LOAD;
            pad_sel_q <= target_q;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_LOAD: begin
          active_q    <= target_q;
          state_q     <= ST_ACTIVE;
          ready_q     <= 1'b1;
          switching_q <= 1'b0;
        end
        default: state_q <= ST_ACTIVE;
      endcase
    end
  end

  assign sel_if.o_sel_ready   = ready_q;
  assign sel_if.o_active_slot = active_q;
  assign sel_if.o_switching   = switching_q;
  assign sel_if.o_sel_err     = err_q;

  logic             sel_cmd_in;
  logic [NUMIO-1:0] sel_dat_in;

  always_comb begin
    o_slot_ck     = '0;
    o_slot_cmd_oe = '0;
    o_slot_cmd    = '1;
    o_slot_dat_oe = '0;
    o_slot_dat    = '1;
    sel_cmd_in    = 1'b1;
    sel_dat_in    = '1;
    for (int s = 0; s < NSLOTS; s++) begin
      if (pad_sel_q == SW'(s)) begin
        sel_cmd_in = i_slot_cmd[s];
        sel_dat_in = i_slot_dat[s*NUMIO +: NUMIO];
        if (state_q != ST_GATE) begin
          o_slot_ck[s]                   = i_core_ck;
          o_slot_cmd_oe[s]               = i_core_cmd_oe;
          o_slot_cmd[s]                  = i_core_cmd;
          o_slot_dat_oe[s*NUMIO +: NUMIO] = i_core_dat_oe;
          o_slot_dat[s*NUMIO +: NUMIO]    = i_core_dat;
        end
      end
    end
  end

  assign o_core_cmd = switching_q ? 1'b1 : sel_cmd_in;
  assign o_core_dat = switching_q ? '1 : sel_dat_in;

  logic [NSLOTS-1:0] chg;

  for (genvar g = 0; g < NSLOTS; g++) begin : g_deb
    sdio_cdebounce #(.LGDEBOUNCE(LGDEBOUNCE)) u_deb (
      .i_clk         (i_clk),
      .i_reset_n     (i_reset_n),
      .i_card_detect (i_card_detect[g]),
      .o_present     (o_card_present[g]),
      .o_chg         (chg[g])
    );
  end

  assign o_present_chg = |chg;

endmodule

// File: tb/tb_sdio_slotmux.sv
// Scoreboard bench for sdio_slotmux: NSLOTS=4, NUMIO=4, LGDEBOUNCE=4, SETTLE=8.
module tb_sdio_slotmux;

  localparam int EV_ERR  = 0;
  localparam int EV_DONE = 1;
  localparam int EV_CHG  = 2;

  typedef struct {
    int    kind;
    int    val;
    int    cyc;
    string name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_busy, card_busy;
  logic        core_ck, core_cmd_oe, core_cmd;
  logic [3:0]  core_dat_oe, core_dat;
  logic        core_cmd_out;
  logic [3:0]  core_dat_out;
  logic [3:0]  slot_ck, slot_cmd_oe, slot_cmd, slot_cmd_in;
  logic [15:0] slot_dat_oe, slot_dat, slot_dat_in;
  logic [3:0]  card_det, present;
  logic        present_chg;
  logic        prev_sw;

  sdio_slotmux_if #(.SW(3)) sel_if ();

  sdio_slotmux #(
    .NSLOTS(4), .NUMIO(4), .LGDEBOUNCE(4), .SETTLE(8)
  ) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .sel_if         (sel_if),
    .i_bus_busy     (bus_busy),
    .i_card_busy    (card_busy),
    .i_core_ck      (core_ck),
    .i_core_cmd_oe  (core_cmd_oe),
    .i_core_cmd     (core_cmd),
    .i_core_dat_oe  (core_dat_oe),
    .i_core_dat     (core_dat),
    .o_core_cmd     (core_cmd_out),
    .o_core_dat     (core_dat_out),
    .o_slot_ck      (slot_ck),
    .o_slot_cmd_oe  (slot_cmd_oe),
    .o_slot_cmd     (slot_cmd),
    .o_slot_dat_oe  (slot_dat_oe),
    .o_slot_dat     (slot_dat),
    .i_slot_cmd     (slot_cmd_in),
    .i_slot_dat     (slot_dat_in),
    .i_card_detect  (card_det),
    .o_card_present (present),
    .o_present_chg  (present_chg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_evt(input int kind, input int val);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d value %0h at cycle %0d, required none", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s: got kind %0d value %0h cycle %0d, required kind %0d value %0h cycle %0d",
                 e.name, kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sw = 1'b0;
    end else begin
      if (sel_if.o_sel_err) check_evt(EV_ERR, int'(sel_if.o_active_slot));
      if (present_chg) check_evt(EV_CHG, int'(present));
      if (prev_sw && !sel_if.o_switching) check_evt(EV_DONE, int'(sel_if.o_active_slot));
      prev_sw = sel_if.o_switching;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int val, input int at, input string name);
    exp_t e;
    e.kind = kind; e.val = val; e.cyc = at; e.name = name;
    exp_q.push_back(e);
  endtask

  // Pads with core driving ck=1, cmd=0 (oe), dat=5 (oe): k<0 means all idle.
  task automatic chk_pads(input string name, input int k);
    logic [15:0] dv, dov;
    logic [3:0]  ckv, cmdv;
    dv = 16'hFFFF; dov = 16'h0000; ckv = 4'h0; cmdv = 4'hF;
    if (k >= 0) begin
      dv[4*k +: 4]  = 4'h5;
      dov[4*k +: 4] = 4'hF;
      ckv[k]        = 1'b1;
      cmdv[k]       = 1'b0;
    end
    chk({name, "_ck"}, 32'(slot_ck), 32'(ckv));
    chk({name, "_cmd"}, 32'(slot_cmd), 32'(cmdv));
    chk({name, "_dat"}, 32'(slot_dat), 32'(dv));
    chk({name, "_dat_oe"}, 32'(slot_dat_oe), 32'(dov));
  endtask

  initial begin
    int h, c;
    rst_n = 1'b0;
    sel_if.i_sel_valid = 1'b0;
    sel_if.i_sel_slot  = '0;
    bus_busy = 1'b0; card_busy = 1'b0;
    core_ck = 1'b1; core_cmd_oe = 1'b1; core_cmd = 1'b0;
    core_dat_oe = 4'hF; core_dat = 4'h5;
    slot_cmd_in = 4'b1010; slot_dat_in = 16'h4321;
    card_det = 4'h0;
    tick(); tick();
    #1;
    chk("rst_active", 32'(sel_if.o_active_slot), 0);
    chk("rst_ready", 32'(sel_if.o_sel_ready), 1);
    chk("rst_switching", 32'(sel_if.o_switching), 0);
    chk("rst_err", 32'(sel_if.o_sel_err), 0);
    chk("rst_present", 32'(present), 0);
    chk("rst_chg", 32'(present_chg), 0);
    chk_pads("rst_pads", 0);
    chk("rst_core_cmd", 32'(core_cmd_out), 0);
    chk("rst_core_dat", 32'(core_dat_out), 1);
    tick();
    rst_n = 1'b1;

    // Request the current slot: nothing should move.
    tick();
    sel_if.i_sel_valid = 1'b1; sel_if.i_sel_slot = 3'd0;
    tick();
    sel_if.i_sel_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      chk("same_switching", 32'(sel_if.o_switching), 0);
      chk("same_ck", 32'(slot_ck), 32'h1);
      chk("same_core_dat", 32'(core_dat_out), 1);
    end

    // Out-of-range request.
    tick();
    h = cyc + 1;
    sel_if.i_sel_valid = 1'b1; sel_if.i_sel_slot = 3'd5;
    push(EV_ERR, 0, h, "sel_err_pulse");
    tick();
    sel_if.i_sel_valid = 1'b0;
    #1;
    chk("err_ready", 32'(sel_if.o_sel_ready), 1);
    chk("err_active", 32'(sel_if.o_active_slot), 0);
    tick(); #1;
    chk("err_ready2", 32'(sel_if.o_sel_ready), 1);
    chk("err_switching", 32'(sel_if.o_switching), 0);

    // Switch to slot 2 with bus busy for 20 drain cycles.
    tick();
    h = cyc + 1;
    sel_if.i_sel_valid = 1'b1; sel_if.i_sel_slot = 3'd2;
    bus_busy = 1'b1;
    push(EV_DONE, 2, h + 30, "switch_to_2_done");
    for (int d = 0; d <= 30; d++) begin
      tick();
      sel_if.i_sel_valid = 1'b0;
      if (d == 20) bus_busy = 1'b0;
      #1;
      if (d == 1 || d == 20) begin
        chk("drain_ck", 32'(slot_ck), 32'h1);
        chk("drain_core_cmd", 32'(core_cmd_out), 1);
        chk("drain_ready", 32'(sel_if.o_sel_ready), 0);
      end
      if (d >= 21 && d <= 28) chk("gate_ck", 32'(slot_ck), 0);
      if (d == 21) chk_pads("gate_pads", -1);
      if (d == 30) begin
        chk_pads("slot2_pads", 2);
        chk("slot2_core_dat", 32'(core_dat_out), 3);
        chk("slot2_core_cmd", 32'(core_cmd_out), 0);
      end
    end

    // Card busy outlasts bus busy: DRAIN must hold.
    tick();
    h = cyc + 1;
    sel_if.i_sel_valid = 1'b1; sel_if.i_sel_slot = 3'd1;
    bus_busy = 1'b1; card_busy = 1'b1;
    push(EV_DONE, 1, h + 18, "switch_to_1_done");
    for (int d = 0; d <= 18; d++) begin
      tick();
      sel_if.i_sel_valid = 1'b0;
      if (d == 3) bus_busy = 1'b0;
      if (d == 8) card_busy = 1'b0;
      #1;
      if (d >= 4 && d <= 8) chk("cbusy_drain_ck", 32'(slot_ck), 32'h4);
      if (d == 9) chk("cbusy_gate_ck", 32'(slot_ck), 0);
      if (d == 18) chk("slot1_core_dat", 32'(core_dat_out), 2);
    end

    // Reset while gating toward slot 3.
    tick();
    sel_if.i_sel_valid = 1'b1; sel_if.i_sel_slot = 3'd3;
    for (int d = 0; d <= 3; d++) begin
      tick();
      sel_if.i_sel_valid = 1'b0;
    end
    chk("pre_rst_gate_ck", 32'(slot_ck), 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_active", 32'(sel_if.o_active_slot), 0);
    chk("midrst_ready", 32'(sel_if.o_sel_ready), 1);
    chk("midrst_switching", 32'(sel_if.o_switching), 0);
    chk_pads("midrst_pads", 0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); #1;
    chk("postrst_active", 32'(sel_if.o_active_slot), 0);
    chk("postrst_ck", 32'(slot_ck), 32'h1);
    chk("postrst_core_dat", 32'(core_dat_out), 1);
    chk("postrst_ready", 32'(sel_if.o_sel_ready), 1);

    // Card-detect glitch shorter than the debounce window.
    tick();
    card_det = 4'b0010;
    repeat (10) tick();
    card_det = 4'b0000;
    repeat (20) tick();
    chk("glitch_present", 32'(present), 0);

    // Two cards inserted together: one pulse.
    c = cyc;
    card_det = 4'b1010;
    push(EV_CHG, 4'b1010, c + 18, "insert_chg");
    repeat (16) tick();
    chk("insert_not_yet", 32'(present), 0);
    repeat (10) tick();
    chk("insert_present", 32'(present), 32'hA);

    // Removal of one card.
    c = cyc;
    card_det = 4'b1000;
    push(EV_CHG, 4'b1000, c + 18, "remove_chg");
    repeat (25) tick();
    chk("remove_present", 32'(present), 32'h8);

    repeat (5) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        $display("FAIL %s: event not seen by cycle %0d, required at cycle %0d", e.name, cyc, e.cyc);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
